// File: rtl/dsp_chain_acc_drain.sv
// Drain stage for a DSP slice cascade: accumulates groups of chain partial sums,
// then rounds, shifts and saturates each group total into a small output FIFO.
module dsp_chain_acc_drain #(
  parameter int IN_W  = 37,
  parameter int ACC_W = 48,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int AW = $clog2(DEPTH);

  // Rounding constant 2^(SHIFT-1); evaluates to zero when SHIFT is 0.
  localparam logic signed [ACC_W:0] RND  = ((ACC_W+1)'(1) << SHIFT) >> 1;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state, state_n;
  logic signed [ACC_W-1:0]  acc, acc_n;
  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  s1_data, s1_n;
  logic                     s1_valid, s1_load;
  logic                     beat;

  logic signed [ACC_W:0]    rnd_sum, quot;
  logic [OUT_W-1:0]         res_data;
  logic                     res_sat;

  logic [OUT_W-1:0]         mem_data [DEPTH];
  logic                     mem_sat  [DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;
  logic [OUT_W-1:0]         hold_data;
  logic                     hold_sat;
  logic                     push, pop;
  logic [AW+1:0]            occ;

  assign in_ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign beat   = in_valid & in_ready;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    s1_load = 1'b0;
    s1_n    = acc + in_ext;
    case (state)
      IDLE: if (beat) begin
        if (in_last) begin
          s1_load = 1'b1;
          s1_n    = in_ext;
        end else begin
          acc_n   = in_ext;
          state_n = RUN;
        end
      end
      RUN: if (beat) begin
        if (in_last) begin
          s1_load = 1'b1;
          acc_n   = '0;
          state_n = IDLE;
        end else begin
          acc_n   = acc + in_ext;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      s1_valid <= s1_load;
      if (s1_load) s1_data <= s1_n;
    end
  end

  // One guard bit keeps the rounding add from wrapping before the shift.
  always_comb begin
    rnd_sum  = {s1_data[ACC_W-1], s1_data} + RND;
    quot     = rnd_sum >>> SHIFT;
    res_sat  = 1'b0;
    res_data = quot[OUT_W-1:0];
    if (quot > MAXV) begin
      res_data = {1'b0, {(OUT_W-1){1'b1}}};
      res_sat  = 1'b1;
    end else if (quot < MINV) begin
      res_data = {1'b1, {(OUT_W-1){1'b0}}};
      res_sat  = 1'b1;
    end
  end

  assign push = s1_valid;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= res_data;
      mem_sat[wr_ptr]  <= res_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_data <= '0;
      hold_sat  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_data <= mem_data[rd_ptr];
        hold_sat  <= mem_sat[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr] : hold_data;
  assign out_sat   = out_valid ? mem_sat[rd_ptr]  : hold_sat;

  // Credit counts results still in the pipe so a stalled FIFO can never overflow.
  assign occ      = (AW+2)'(count) + (AW+2)'(s1_valid);
  assign in_ready = ~reset & (occ < (AW+2)'(DEPTH));

endmodule

// File: tb/tb_dsp_chain_acc_drain.sv
// Self-checking bench for dsp_chain_acc_drain: directed scenarios plus randomized
// groups compared against an arithmetic reference of the group result.
module tb_dsp_chain_acc_drain;

  localparam int SH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [36:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;

  dsp_chain_acc_drain #(.IN_W(37), .ACC_W(48), .OUT_W(16), .SHIFT(SH), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        s;
  } res_t;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  longint gsum = 0;
  bit     rnd_rdy = 0;
  res_t   exp_q[$];
  res_t   got_q[$];
  longint got_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (!reset && out_valid && out_ready) begin
      got_q.push_back('{out_data, out_sat});
      got_cyc.push_back(cyc);
    end
  end

  // Group total wraps at 48 bits, then round-half-up division by 2^SH and clamp.
  function automatic res_t model(input longint total);
    res_t   r;
    longint t, x, rem, q;
    t   = (total << 16) >>> 16;
    x   = t + (64'sd1 << (SH - 1));
    rem = ((x % (64'sd1 << SH)) + (64'sd1 << SH)) % (64'sd1 << SH);
    q   = (x - rem) / (64'sd1 << SH);
    r.s = 1'b0;
    if (q > 32767)       begin q = 32767;  r.s = 1'b1; end
    else if (q < -32768) begin q = -32768; r.s = 1'b1; end
    r.d = 16'(q);
    return r;
  endfunction

  task automatic send_beat(input longint v, input bit last, output int stalls);
    int w;
    w = 0;
    in_data  = 37'(v);
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    stalls = w;
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, w);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    gsum += v;
    if (last) begin
      exp_q.push_back(model(gsum));
      gsum = 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string tag, input int maxc);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d results, required %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i].d !== exp_q[i].d || got_q[i].s !== exp_q[i].s) begin
        fails++;
        $display("FAIL %s_result[%0d]: got data=%0d sat=%0b, required data=%0d sat=%0b",
                 tag, i, $signed(got_q[i].d), got_q[i].s, $signed(exp_q[i].d), exp_q[i].s);
      end
    end
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  task automatic check_bit(input string tag, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0b, required %0b", tag, act, req);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] d, input logic s);
    tests++;
    if (out_valid !== 1'b1 || out_data !== d || out_sat !== s) begin
      fails++;
      $display("FAIL %s: got valid=%0b data=%0d sat=%0b, required valid=1 data=%0d sat=%0b",
               tag, out_valid, $signed(out_data), out_sat, $signed(d), s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b0);
    check_bit("reset_out_sat", out_sat, 1'b0);
    tests++;
    if (out_data !== 16'd0) begin
      fails++;
      $display("FAIL reset_out_data: got %0d, required 0", out_data);
    end
    reset = 1'b0;
    #1;
    check_bit("release_in_ready", in_ready, 1'b1);
    got_q.delete();
  endtask

  task automatic test_group();
    int st;
    out_ready = 1'b1;
    send_beat(256, 0, st);
    send_beat(512, 0, st);
    send_beat(768, 1, st);
    check_bit("group_latency_n1", out_valid, 1'b0);
    @(posedge clk); #1;
    check_out("group_latency_n2", 16'd6, 1'b0);
    drain("group", 50);
  endtask

  task automatic test_rounding();
    int st;
    out_ready = 1'b1;
    send_beat(384, 1, st);
    @(posedge clk); #1;
    check_out("round_pos", 16'd2, 1'b0);
    send_beat(-384, 1, st);
    @(posedge clk); #1;
    check_out("round_neg", 16'hFFFF, 1'b0);
    drain("round", 50);
  endtask

  task automatic test_saturation();
    int st;
    out_ready = 1'b1;
    send_beat(64'sd1 << 30, 1, st);
    @(posedge clk); #1;
    check_out("sat_pos", 16'h7FFF, 1'b1);
    send_beat(-(64'sd1 << 30), 1, st);
    @(posedge clk); #1;
    check_out("sat_neg", 16'h8000, 1'b1);
    drain("sat", 50);
  endtask

  task automatic test_backpressure();
    int st;
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) send_beat(256 * k, 1, st);
    check_bit("bp_ready_after3", in_ready, 1'b1);
    send_beat(1024, 1, st);
    check_bit("bp_ready_after4", in_ready, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_bit("bp_ready_hold", in_ready, 1'b0);
    check_out("bp_head_stable", 16'd1, 1'b0);
    out_ready = 1'b1;
    send_beat(256 * 5, 1, st);
    send_beat(256 * 6, 1, st);
    drain("bp", 100);
  endtask

  task automatic test_reset_mid();
    int st;
    out_ready = 1'b0;
    send_beat(256, 1, st);
    send_beat(512, 1, st);
    repeat (2) @(posedge clk);
    #1;
    send_beat(1000, 0, st);
    send_beat(2000, 0, st);
    check_bit("rmid_fifo_occupied", out_valid, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_bit("rmid_out_valid", out_valid, 1'b0);
    check_bit("rmid_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    check_bit("rmid_release_ready", in_ready, 1'b1);
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    gsum = 0;
    out_ready = 1'b1;
    send_beat(512, 1, st);
    drain("rmid", 50);
  endtask

  task automatic test_back_to_back();
    int st, tot, n;
    longint span;
    out_ready = 1'b1;
    tot = 0;
    for (int k = 0; k < 8; k++) begin
      send_beat(longint'($urandom_range(0, 200000)) - 100000, 1, st);
      tot += st;
    end
    n = 0;
    while (got_q.size() < 8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (tot != 0) begin
      fails++;
      $display("FAIL b2b_stalls: got %0d stall cycles, required 0", tot);
    end
    span = (got_cyc.size() >= 8) ? got_cyc[7] - got_cyc[0] : -1;
    tests++;
    if (span != 7) begin
      fails++;
      $display("FAIL b2b_span: got %0d cycles for 8 results, required 7", span);
    end
    drain("b2b", 50);
  endtask

  task automatic test_random();
    int st, len;
    logic [63:0] rv;
    logic signed [36:0] s37;
    longint v;
    rnd_rdy = 1'b1;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        rv  = {$urandom, $urandom};
        s37 = rv[36:0];
        if ($urandom_range(0, 2) == 0) v = s37;
        else if ($urandom_range(0, 1) == 0) v = longint'(s37 >>> 14);
        else v = longint'($urandom_range(0, 20000)) - 10000;
        send_beat(v, (b == len - 1), st);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain("rand", 2000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_group();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
